// File: rtl/apb_master.sv
// rtl/apb_master.sv - APB requester bridging a valid/ready command/response pair onto APB.
// One transfer in flight; an ACCESS phase held too long without PREADY is aborted as a timeout.
module apb_master #(
  parameter int AWIDTH  = 4,
  parameter int DWIDTH  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [AWIDTH-1:0] cmd_addr,
  input  logic [DWIDTH-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DWIDTH-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [AWIDTH-1:0] PADDR,
  output logic [DWIDTH-1:0] PWDATA,
  input  logic [DWIDTH-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT);

  state_t     r_state;
  logic [7:0] r_wait_cnt;

  // A pending response blocks new commands, which also guarantees an IDLE gap.
  assign cmd_ready = (r_state == IDLE) && !rsp_valid;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state     <= IDLE;
      r_wait_cnt  <= 8'd0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            PWRITE     <= cmd_write;
            PADDR      <= cmd_addr;
            PWDATA     <= cmd_wdata;
            PSEL       <= 1'b1;
            PENABLE    <= 1'b0;
            r_wait_cnt <= 8'd0;
            r_state    <= SETUP;
          end
        end

        SETUP: begin
          PENABLE <= 1'b1;
          r_state <= ACCESS;
        end

        ACCESS: begin
          // PREADY is checked first so a late completer still wins over the timeout.
          if (PREADY) begin
            rsp_valid   <= 1'b1;
            rsp_rdata   <= PWRITE ? '0 : PRDATA;
            rsp_err     <= PSLVERR;
            rsp_timeout <= 1'b0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            r_state     <= IDLE;
          end else if (r_wait_cnt == LP_TIMEOUT) begin
            rsp_valid   <= 1'b1;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            r_state     <= IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end

        default: begin
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - Directed vector bench for apb_master with a small APB completer driver.
module tb_apb_master;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int TO = 3;
  localparam int NEVER = 255;

  logic          PCLK = 1'b0;
  logic          PRESETn;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic          PSEL, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA, PRDATA;
  logic          PREADY, PSLVERR;

  int checks = 0;
  int failures = 0;

  apb_master #(.AWIDTH(AW), .DWIDTH(DW), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            nwait;
    logic [DW-1:0] prdata;
    logic          pslverr;
    int            bp;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
    logic          exp_to;
    int            exp_lat;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // All sampling and driving happens at negedges; cyc 0 is the acceptance cycle.
  task automatic run_vec(input vec_t v);
    int  w;
    int  cyc;
    bit  done;
    cmd_valid = 1'b1;
    cmd_write = v.write;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    PREADY    = 1'b0;
    rsp_ready = 1'b0;
    w = 0;
    while (!cmd_ready && w < 10) begin
      @(negedge PCLK);
      w++;
    end
    check("cmd_ready_idle", cmd_ready, 1);
    @(negedge PCLK);
    cmd_valid = 1'b0;
    cmd_write = ~v.write;
    cmd_addr  = ~v.addr;
    cmd_wdata = ~v.wdata;
    check("setup_psel_penable", {PSEL, PENABLE}, 2'b10);
    check("setup_paddr", PADDR, v.addr);
    check("setup_pwrite", PWRITE, v.write);
    check("setup_pwdata", PWDATA, v.wdata);
    cyc  = 1;
    done = 0;
    while (!done && cyc < 40) begin
      @(negedge PCLK);
      cyc++;
      if (rsp_valid) begin
        done = 1;
      end else begin
        check("access_psel_penable", {PSEL, PENABLE}, 2'b11);
        check("access_paddr", PADDR, v.addr);
        check("access_pwdata", PWDATA, v.wdata);
        PREADY  = (cyc - 2 == v.nwait);
        PRDATA  = PREADY ? v.prdata : ~v.prdata;
        PSLVERR = PREADY ? v.pslverr : ~v.pslverr;
      end
    end
    PREADY = 1'b0;
    check("rsp_seen", done, 1);
    check("latency", cyc, v.exp_lat);
    check("rsp_rdata", rsp_rdata, v.exp_rdata);
    check("rsp_err", rsp_err, v.exp_err);
    check("rsp_timeout", rsp_timeout, v.exp_to);
    check("done_psel_penable", {PSEL, PENABLE}, 2'b00);
    if (v.bp > 0) begin
      cmd_valid = 1'b1;
      for (int i = 0; i < v.bp; i++) begin
        @(negedge PCLK);
        check("bp_cmd_ready", cmd_ready, 0);
        check("bp_psel", PSEL, 0);
        check("bp_rsp_valid", rsp_valid, 1);
        check("bp_rsp_rdata", rsp_rdata, v.exp_rdata);
        check("bp_rsp_err", {rsp_err, rsp_timeout}, {v.exp_err, v.exp_to});
      end
    end
    rsp_ready = 1'b1;
    @(negedge PCLK);
    rsp_ready = 1'b0;
    cmd_valid = (v.bp > 0);
    check("rsp_cleared", rsp_valid, 0);
    check("cmd_ready_after_hs", cmd_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //          wr    addr   wdata  nw     prdata pslv bp exp_rd err to lat
    vecs[0] = '{1'b1, 4'h2, 8'hA5, 0,     8'h11, 1'b0, 0, 8'h00, 1'b0, 1'b0, 3};
    vecs[1] = '{1'b0, 4'h6, 8'h00, 2,     8'h3C, 1'b0, 4, 8'h3C, 1'b0, 1'b0, 5};
    vecs[2] = '{1'b0, 4'hF, 8'h00, 0,     8'h5A, 1'b1, 0, 8'h5A, 1'b1, 1'b0, 3};
    vecs[3] = '{1'b0, 4'h1, 8'h00, NEVER, 8'h77, 1'b0, 0, 8'h00, 1'b1, 1'b1, 6};
    vecs[4] = '{1'b0, 4'h9, 8'h00, TO,    8'hC3, 1'b0, 0, 8'hC3, 1'b0, 1'b0, 6};
    vecs[5] = '{1'b1, 4'h7, 8'h5E, 1,     8'h99, 1'b1, 0, 8'h00, 1'b1, 1'b0, 4};
    vecs[6] = '{1'b0, 4'h3, 8'h00, 0,     8'h81, 1'b0, 0, 8'h81, 1'b0, 1'b0, 3};

    PRESETn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    PRDATA    = '0;
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;
    repeat (3) @(negedge PCLK);
    check("rst_apb_ctrl", {PSEL, PENABLE, PWRITE}, 3'b000);
    check("rst_paddr", PADDR, 0);
    check("rst_pwdata", PWDATA, 0);
    check("rst_rsp", {rsp_valid, rsp_err, rsp_timeout}, 3'b000);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    PRESETn = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i]);
    end

    check("idle_paddr_hold", PADDR, vecs[6].addr);

    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 4'h4;
    cmd_wdata = 8'h42;
    PREADY    = 1'b0;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    check("rstseq_setup", {PSEL, PENABLE}, 2'b10);
    @(negedge PCLK);
    check("rstseq_access", {PSEL, PENABLE}, 2'b11);
    PRESETn = 1'b0;
    #1;
    check("rstseq_async_drop", {PSEL, PENABLE}, 2'b00);
    check("rstseq_paddr", PADDR, 0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    repeat (3) begin
      @(negedge PCLK);
      check("rstseq_no_rsp", rsp_valid, 0);
      check("rstseq_psel", PSEL, 0);
    end
    run_vec(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
